// File: rtl/kernel_start_ctrl_pkg.sv
// Shared definitions for the kernel start controller.
//   - Register word offsets on the Avalon-MM slave
//   - Bit positions inside CTRL and STATUS
//   - Sequencer state encoding
package kernel_ctrl_pkg;

  localparam logic [1:0] RegCtrl    = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegTimeout = 2'd2;
  localparam logic [1:0] RegCycles  = 2'd3;

  // CTRL bits
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned CtrlAbortBit = 2;

  // STATUS bits
  localparam int unsigned StatBusyBit = 0;
  localparam int unsigned StatDoneBit = 1;
  localparam int unsigned StatToutBit = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2
  } kstate_e;

endpackage

// File: rtl/kernel_start_ctrl_if.sv
// Avalon-MM slave bus for the kernel start controller.
//   address    : word offset (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit combinational read data
// master: CPU side, slave: controller side.
interface kernel_start_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/kernel_start_ctrl_cycle_counter.sv
// Saturating run-cycle counter.
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear (wins over en)
//   en           : advance by one, sticking at all-ones
//   cmp_val      : compare value
//   count        : current count
//   next_eq      : the value the counter would take if enabled equals cmp_val
module kernel_cycle_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] cmp_val,
  output logic [CNT_W-1:0] count,
  output logic             next_eq
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;

  always_comb begin
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    next_eq   = (count_inc == cmp_val);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_inc;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/kernel_start_ctrl.sv
// Sequences one run of the CNN accelerator kernel from the Nios data master.
//   clk, reset_n : clock, async active-low reset
//   bus          : Avalon-MM slave (CTRL, STATUS, TIMEOUT, CYCLES registers)
//   kernel_start : registered one-cycle start pulse to the kernel
//   kernel_done  : kernel completion, only looked at while running
//   irq          : registered level interrupt, IRQ_EN & (DONE | TIMEOUT)
module kernel_start_ctrl
  import kernel_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  kernel_start_ctrl_if.slave  bus,
  output logic                kernel_start,
  input  logic                kernel_done,
  output logic                irq
);

  kstate_e          state_q, state_d;
  logic             kernel_start_q;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;
  logic             irq_q;
  logic [CNT_W-1:0] timeout_q, timeout_d;

  logic             wr, wr_ctrl, wr_status, wr_timeout;
  logic             start_req, abort_req;
  logic             cnt_clr, cnt_en, cnt_match;
  logic             set_done, set_tout;
  logic [CNT_W-1:0] cycles;

  kernel_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cmp_val (timeout_q),
    .count   (cycles),
    .next_eq (cnt_match)
  );

  always_comb begin
    wr         = bus.chipselect & ~bus.write_n;
    wr_ctrl    = wr & (bus.address == RegCtrl);
    wr_status  = wr & (bus.address == RegStatus);
    wr_timeout = wr & (bus.address == RegTimeout);
    // ABORT in the same write suppresses START
    start_req  = wr_ctrl & bus.writedata[CtrlStartBit] & ~bus.writedata[CtrlAbortBit];
    abort_req  = wr_ctrl & bus.writedata[CtrlAbortBit];
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    set_done = 1'b0;
    set_tout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d = StStart;
          cnt_clr = 1'b1;
        end
      end
      StStart: begin
        state_d = abort_req ? StIdle : StRun;
      end
      StRun: begin
        if (abort_req) begin
          state_d = StIdle;
        end else begin
          cnt_en = 1'b1;
          // done takes priority over a simultaneous timeout match
          if (kernel_done) begin
            set_done = 1'b1;
            state_d  = StIdle;
          end else if ((timeout_q != '0) && cnt_match) begin
            set_tout = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    irq_en_d  = wr_ctrl ? bus.writedata[CtrlIrqEnBit] : irq_en_q;
    // hardware set beats a same-cycle W1C
    done_d    = set_done | (done_q & ~(wr_status & bus.writedata[StatDoneBit]));
    tout_d    = set_tout | (tout_q & ~(wr_status & bus.writedata[StatToutBit]));
    timeout_d = wr_timeout ? bus.writedata[CNT_W-1:0] : timeout_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      kernel_start_q <= 1'b0;
      irq_en_q       <= 1'b0;
      done_q         <= 1'b0;
      tout_q         <= 1'b0;
      irq_q          <= 1'b0;
      timeout_q      <= '0;
    end else begin
      state_q        <= state_d;
      // high exactly while the FSM sits in StStart
      kernel_start_q <= (state_d == StStart);
      irq_en_q       <= irq_en_d;
      done_q         <= done_d;
      tout_q         <= tout_d;
      irq_q          <= irq_en_q & (done_q | tout_q);
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      RegCtrl: begin
        bus.readdata[CtrlIrqEnBit] = irq_en_q;
      end
      RegStatus: begin
        bus.readdata[StatBusyBit] = (state_q != StIdle);
        bus.readdata[StatDoneBit] = done_q;
        bus.readdata[StatToutBit] = tout_q;
      end
      RegTimeout: bus.readdata = 32'(timeout_q);
      RegCycles:  bus.readdata = 32'(cycles);
      default:    bus.readdata = '0;
    endcase
  end

  assign kernel_start = kernel_start_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_kernel_start_ctrl.sv
// Directed self-checking bench for kernel_start_ctrl.
module tb_kernel_start_ctrl;

  logic clk;
  logic reset_n;
  logic kernel_start;
  logic kernel_done;
  logic irq;

  int n_checks = 0;
  int n_fail   = 0;
  int ks_cnt   = 0;
  int ks_base;

  kernel_start_ctrl_if bus ();

  kernel_start_ctrl #(
    .CNT_W (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .kernel_start (kernel_start),
    .kernel_done  (kernel_done),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulses seen while the clock is low, i.e. away from the active edge
  always @(negedge clk) if (kernel_start) ks_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; the write is taken at the next posedge, returns at the following negedge.
  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic rd_chk(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    check_eq(tag, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    kernel_done    = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 1: reset state
    rd_chk(2'd0, 32'h0, "rst_ctrl");
    rd_chk(2'd1, 32'h0, "rst_status");
    rd_chk(2'd2, 32'h0, "rst_timeout");
    rd_chk(2'd3, 32'h0, "rst_cycles");
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_ks", 32'(kernel_start), 32'h0);

    // 2: normal run, done on the 4th RUN cycle
    ks_base = ks_cnt;
    tick();
    wr(2'd0, 32'h3);                          // now in START
    check_eq("t2_ks_high", 32'(kernel_start), 32'h1);
    rd_chk(2'd1, 32'h1, "t2_busy_start");
    tick();                                   // RUN1
    check_eq("t2_ks_low", 32'(kernel_start), 32'h0);
    tick();                                   // RUN2
    tick();                                   // RUN3
    tick();                                   // RUN4
    kernel_done = 1'b1;
    tick();                                   // IDLE
    kernel_done = 1'b0;
    rd_chk(2'd1, 32'h2, "t2_status");
    rd_chk(2'd3, 32'd4, "t2_cycles");
    rd_chk(2'd0, 32'h2, "t2_ctrl_irqen");
    check_eq("t2_irq_lag", 32'(irq), 32'h0);
    check_eq("t2_ks_count", 32'(ks_cnt - ks_base), 32'd1);
    tick();
    check_eq("t2_irq_set", 32'(irq), 32'h1);
    wr(2'd1, 32'h2);
    rd_chk(2'd1, 32'h0, "t2_w1c");
    tick();
    check_eq("t2_irq_clr", 32'(irq), 32'h0);

    // 3a: timeout of 5 cycles
    wr(2'd2, 32'd5);
    rd_chk(2'd2, 32'd5, "t3_timeout_rd");
    tick();
    wr(2'd0, 32'h3);                          // START
    repeat (5) tick();                        // RUN5
    rd_chk(2'd1, 32'h1, "t3_busy_run5");
    tick();                                   // IDLE
    rd_chk(2'd1, 32'h4, "t3_status_tout");
    rd_chk(2'd3, 32'd5, "t3_cycles_tout");
    tick();
    check_eq("t3_irq_tout", 32'(irq), 32'h1);
    wr(2'd1, 32'h4);
    rd_chk(2'd1, 32'h0, "t3_w1c_tout");

    // 3b: done coincides with the timeout match
    tick();
    wr(2'd0, 32'h3);
    repeat (5) tick();                        // RUN5
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
    rd_chk(2'd1, 32'h2, "t3_done_wins");
    rd_chk(2'd3, 32'd5, "t3_cycles_done");
    wr(2'd1, 32'h2);
    wr(2'd2, 32'd0);

    // 4: START while busy is ignored, then ABORT
    ks_base = ks_cnt;
    tick();
    wr(2'd0, 32'h1);                          // START
    tick();                                   // RUN1
    tick();                                   // RUN2
    wr(2'd0, 32'h1);                          // ignored, now RUN3
    rd_chk(2'd3, 32'd2, "t4_cycles_run3");
    rd_chk(2'd1, 32'h1, "t4_busy");
    tick();                                   // RUN4
    rd_chk(2'd3, 32'd3, "t4_cycles_run4");
    wr(2'd0, 32'h4);                          // ABORT -> IDLE
    rd_chk(2'd1, 32'h0, "t4_status_abort");
    rd_chk(2'd3, 32'd3, "t4_cycles_abort");
    tick();
    rd_chk(2'd3, 32'd3, "t4_cycles_hold");
    check_eq("t4_ks_count", 32'(ks_cnt - ks_base), 32'd1);

    // 5: START+ABORT in one write
    ks_base = ks_cnt;
    wr(2'd0, 32'h5);
    check_eq("t5_no_ks", 32'(kernel_start), 32'h0);
    rd_chk(2'd1, 32'h0, "t5_not_busy");
    tick();
    rd_chk(2'd1, 32'h0, "t5_not_busy2");
    check_eq("t5_ks_count", 32'(ks_cnt - ks_base), 32'd0);

    // 6: reset mid-run with DONE set
    wr(2'd2, 32'd9);
    tick();
    wr(2'd0, 32'h3);
    tick();                                   // RUN1
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
    tick();
    check_eq("t6_irq_pre", 32'(irq), 32'h1);
    wr(2'd0, 32'h3);                          // START with DONE still set
    check_eq("t6_ks_pre", 32'(kernel_start), 32'h1);
    rd_chk(2'd1, 32'h3, "t6_busy_done");
    tick();                                   // RUN1
    tick();                                   // RUN2
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_ks", 32'(kernel_start), 32'h0);
    check_eq("t6_rst_irq", 32'(irq), 32'h0);
    rd_chk(2'd0, 32'h0, "t6_rst_ctrl");
    rd_chk(2'd1, 32'h0, "t6_rst_status");
    rd_chk(2'd2, 32'h0, "t6_rst_timeout");
    rd_chk(2'd3, 32'h0, "t6_rst_cycles");
    tick();
    reset_n = 1'b1;
    tick();
    wr(2'd0, 32'h1);                          // START
    check_eq("t6_ks_after", 32'(kernel_start), 32'h1);
    tick();                                   // RUN1
    tick();                                   // RUN2
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
    rd_chk(2'd1, 32'h2, "t6_status_after");
    rd_chk(2'd3, 32'd2, "t6_cycles_after");
    tick();
    check_eq("t6_irq_off", 32'(irq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
